mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 35 +++
 rtl/mem_access_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/response and downstream memory command bundle for mem_access_ctrl.
// slave is the controller's view; master is the requester plus memory side.
interface mem_access_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;

   logic                  rsp_valid;
   logic                  rsp_err;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   logic                  mem_rd_enable;
   logic                  mem_wr_enable;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wr_data;
   logic                  mem_busy;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_busy, mem_rd_data,
      output req_ready, rsp_valid, rsp_err, rsp_rdata,
             mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_busy, mem_rd_data,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata,
             mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding memory access controller: accepts one request, waits out
// mem_busy (with timeout), issues a one-cycle command and returns a response pulse.
module mem_access_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int RD_LATENCY = 1,
   parameter int TIMEOUT    = 255
) (
   input logic          clk,
   input logic          reset,
   mem_access_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ISSUE,
      RD_WAIT,
      RESP
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
   localparam logic [3:0] RD_LAST      = 4'(RD_LATENCY);

   state_t                r_state;
   logic                  r_we;
   logic [7:0]            r_wait_cnt;
   logic [3:0]            r_lat_cnt;
   logic                  r_req_ready;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_mem_rd_en;
   logic                  r_mem_wr_en;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wr_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_we          <= 1'b0;
         r_wait_cnt    <= '0;
         r_lat_cnt     <= '0;
         r_req_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_rsp_rdata   <= '0;
         r_mem_rd_en   <= 1'b0;
         r_mem_wr_en   <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wr_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // ready rises one edge after reset release, so no accept on that edge
               if (!r_req_ready) begin
                  r_req_ready <= 1'b1;
               end else if (bus.req_valid) begin
                  r_req_ready   <= 1'b0;
                  r_we          <= bus.req_we;
                  r_mem_addr    <= bus.req_addr;
                  r_mem_wr_data <= bus.req_wdata;
                  r_wait_cnt    <= '0;
                  r_state       <= WAIT;
               end
            end

            WAIT: begin
               if (!bus.mem_busy) begin
                  r_mem_rd_en <= !r_we;
                  r_mem_wr_en <= r_we;
                  r_state     <= ISSUE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
                  if (r_wait_cnt == TIMEOUT_LAST) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_state     <= RESP;
                  end
               end
            end

            ISSUE: begin
               r_mem_rd_en <= 1'b0;
               r_mem_wr_en <= 1'b0;
               if (r_we) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_state     <= RESP;
               end else begin
                  r_lat_cnt <= 4'd1;
                  r_state   <= RD_WAIT;
               end
            end

            RD_WAIT: begin
               if (r_lat_cnt == RD_LAST) begin
                  r_rsp_rdata <= bus.mem_rd_data;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_state     <= RESP;
               end else begin
                  r_lat_cnt <= r_lat_cnt + 4'd1;
               end
            end

            RESP: begin
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= IDLE;
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready     = r_req_ready;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_err       = r_rsp_err;
   assign bus.rsp_rdata     = r_rsp_rdata;
   assign bus.mem_rd_enable = r_mem_rd_en;
   assign bus.mem_wr_enable = r_mem_wr_en;
   assign bus.mem_addr      = r_mem_addr;
   assign bus.mem_wr_data   = r_mem_wr_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl: main instance with a memory model,
// plus a TIMEOUT=8 instance for the busy-timeout path.
module tb_mem_access_ctrl;
   localparam int DW = 8;
   localparam int AW = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   mem_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

   mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .TIMEOUT(255)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );
   mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .TIMEOUT(8)) dut_to (
      .clk(clk), .reset(reset), .bus(bus2.slave)
   );

   typedef struct {
      logic          err;
      logic [DW-1:0] rdata;
      int            lat;
   } rsp_t;
   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            off;
   } cmd_t;

   rsp_t          rsp_q[$];
   cmd_t          cmd_q[$];
   logic [DW-1:0] ref_mem   [0:65535];
   logic [DW-1:0] mem_model [0:65535];
   logic [DW-1:0] last_rd;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int en2_cnt = 0;

   always @(posedge clk) cyc++;

   // edge index of the accept, so latencies are measured from E0
   always @(negedge clk) if (bus.req_valid && bus.req_ready) acc_cyc = cyc + 1;

   always @(posedge clk) begin
      if (bus.mem_wr_enable) mem_model[bus.mem_addr] <= bus.mem_wr_data;
      if (bus.mem_rd_enable) bus.mem_rd_data <= mem_model[bus.mem_addr];
      if (bus2.mem_rd_enable) bus2.mem_rd_data <= 8'h5A ^ bus2.mem_addr[7:0];
   end

   always @(negedge clk) if (bus2.mem_rd_enable || bus2.mem_wr_enable) en2_cnt++;

   always @(negedge clk) begin : rsp_mon
      rsp_t e;
      if (bus.rsp_valid) begin
         checks++;
         assert (rsp_q.size() != 0) else begin
            errors++; $error("FAIL rsp_unexpected observed rsp_valid=1 expected no response");
         end
         if (rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            checks++;
            assert (bus.rsp_err === e.err) else begin
               errors++; $error("FAIL rsp_err observed %b expected %b", bus.rsp_err, e.err);
            end
            checks++;
            assert (bus.rsp_rdata === e.rdata) else begin
               errors++; $error("FAIL rsp_rdata observed 0x%0h expected 0x%0h", bus.rsp_rdata, e.rdata);
            end
            checks++;
            assert (cyc - acc_cyc === e.lat) else begin
               errors++; $error("FAIL rsp_latency observed %0d expected %0d", cyc - acc_cyc, e.lat);
            end
         end
      end
   end

   always @(negedge clk) begin : cmd_mon
      cmd_t c;
      if (bus.mem_rd_enable || bus.mem_wr_enable) begin
         checks++;
         assert (!(bus.mem_rd_enable && bus.mem_wr_enable)) else begin
            errors++; $error("FAIL both_enables observed rd=1 wr=1 expected one");
         end
         checks++;
         assert (cmd_q.size() != 0) else begin
            errors++; $error("FAIL cmd_unexpected observed enable pulse expected none");
         end
         if (cmd_q.size() != 0) begin
            c = cmd_q.pop_front();
            checks++;
            assert (bus.mem_wr_enable === c.we) else begin
               errors++; $error("FAIL cmd_kind observed wr=%b expected wr=%b", bus.mem_wr_enable, c.we);
            end
            checks++;
            assert (bus.mem_addr === c.addr) else begin
               errors++; $error("FAIL cmd_addr observed 0x%0h expected 0x%0h", bus.mem_addr, c.addr);
            end
            checks++;
            assert (bus.mem_wr_data === c.wdata) else begin
               errors++; $error("FAIL cmd_wdata observed 0x%0h expected 0x%0h", bus.mem_wr_data, c.wdata);
            end
            checks++;
            assert (cyc - acc_cyc === c.off) else begin
               errors++; $error("FAIL cmd_offset observed %0d expected %0d", cyc - acc_cyc, c.off);
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++; $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // k = number of WAIT edges that see mem_busy=1
   task automatic expect_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input int k);
      cmd_t c;
      rsp_t r;
      c.we = we; c.addr = addr; c.wdata = wdata; c.off = 1 + k;
      cmd_q.push_back(c);
      r.err = 1'b0;
      if (we) begin
         ref_mem[addr] = wdata;
         r.rdata = last_rd;
         r.lat = 2 + k;
      end else begin
         last_rd = ref_mem[addr];
         r.rdata = last_rd;
         r.lat = 3 + k;
      end
      rsp_q.push_back(r);
   endtask

   // returns #1 after the accepting edge with req_valid still high
   task automatic drive_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      int n;
      bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (bus.req_ready) break;
         n++;
      end
      check_eq("accept_wait", (n < 100) ? 32'd1 : 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (rsp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("rsp_drain", rsp_q.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin : stim
      int n;
      int en_before;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.mem_busy = 1'b0;
      bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
      bus2.mem_busy = 1'b0;
      last_rd = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_req_ready", bus.req_ready, 0);
      check_eq("rst_rsp_valid", bus.rsp_valid, 0);
      check_eq("rst_rsp_err", bus.rsp_err, 0);
      check_eq("rst_rd_en", bus.mem_rd_enable, 0);
      check_eq("rst_wr_en", bus.mem_wr_enable, 0);
      check_eq("rst_rdata", bus.rsp_rdata, 0);
      check_eq("rst_mem_addr", bus.mem_addr, 0);
      check_eq("rst_mem_wdata", bus.mem_wr_data, 0);

      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_eq("ready_before_edge", bus.req_ready, 0);
      @(posedge clk); #1;
      check_eq("ready_after_release", bus.req_ready, 1);

      // write then read with free memory
      expect_txn(1'b1, 16'h0200, 8'h3C, 0); drive_req(1'b1, 16'h0200, 8'h3C);
      bus.req_valid = 1'b0; wait_done();
      expect_txn(1'b0, 16'h0200, 8'h00, 0); drive_req(1'b0, 16'h0200, 8'h00);
      bus.req_valid = 1'b0; wait_done();
      expect_txn(1'b1, 16'h0200, 8'hA5, 0); drive_req(1'b1, 16'h0200, 8'hA5);
      bus.req_valid = 1'b0; wait_done();
      expect_txn(1'b0, 16'h0200, 8'h00, 0); drive_req(1'b0, 16'h0200, 8'h00);
      bus.req_valid = 1'b0; wait_done();
      expect_txn(1'b1, 16'hFFFF, 8'hFF, 0); drive_req(1'b1, 16'hFFFF, 8'hFF);
      bus.req_valid = 1'b0; wait_done();
      expect_txn(1'b1, 16'h0000, 8'h00, 0); drive_req(1'b1, 16'h0000, 8'h00);
      bus.req_valid = 1'b0; wait_done();
      expect_txn(1'b0, 16'hFFFF, 8'h00, 0); drive_req(1'b0, 16'hFFFF, 8'h00);
      bus.req_valid = 1'b0; wait_done();
      expect_txn(1'b0, 16'h0000, 8'hEE, 0); drive_req(1'b0, 16'h0000, 8'hEE);
      bus.req_valid = 1'b0; wait_done();

      // busy across reset release, drops 18 edges after accept
      reset = 1'b1; bus.mem_busy = 1'b1; last_rd = '0;
      @(posedge clk); #1 reset = 1'b0;
      expect_txn(1'b0, 16'hFFFF, 8'h11, 18); drive_req(1'b0, 16'hFFFF, 8'h11);
      bus.req_valid = 1'b0;
      repeat (18) @(posedge clk);
      #1 bus.mem_busy = 1'b0;
      wait_done();

      // reset during ISSUE of a write
      drive_req(1'b1, 16'h0300, 8'h77);
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("issue_wr_en", bus.mem_wr_enable, 1);
      reset = 1'b1; last_rd = '0;
      #1;
      check_eq("abort_issue_wr_en", bus.mem_wr_enable, 0);
      check_eq("abort_issue_rsp_valid", bus.rsp_valid, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      check_eq("abort_issue_ready", bus.req_ready, 1);

      // reset during RD_WAIT: command expected, response not
      expect_txn(1'b0, 16'h0200, 8'h00, 0);
      rsp_q.delete(rsp_q.size() - 1);
      drive_req(1'b0, 16'h0200, 8'h00);
      bus.req_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1; last_rd = '0;
      #1;
      check_eq("abort_rd_rsp_valid", bus.rsp_valid, 0);
      check_eq("abort_rd_rd_en", bus.mem_rd_enable, 0);
      check_eq("abort_rd_wr_en", bus.mem_wr_enable, 0);
      check_eq("abort_rd_ready", bus.req_ready, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      check_eq("abort_rd_ready_release", bus.req_ready, 1);
      expect_txn(1'b0, 16'h0200, 8'h00, 0); drive_req(1'b0, 16'h0200, 8'h00);
      bus.req_valid = 1'b0; wait_done();

      // req_valid held high across three writes
      expect_txn(1'b1, 16'h0010, 8'h01, 0);
      expect_txn(1'b1, 16'h0011, 8'h02, 0);
      expect_txn(1'b1, 16'h0012, 8'h03, 0);
      drive_req(1'b1, 16'h0010, 8'h01);
      drive_req(1'b1, 16'h0011, 8'h02);
      drive_req(1'b1, 16'h0012, 8'h03);
      bus.req_valid = 1'b0; wait_done();
      expect_txn(1'b0, 16'h0011, 8'h00, 0); drive_req(1'b0, 16'h0011, 8'h00);
      bus.req_valid = 1'b0; wait_done();
      check_eq("cmd_drain", cmd_q.size(), 0);

      // TIMEOUT=8 instance: normal read, then a busy timeout
      bus2.req_we = 1'b0; bus2.req_addr = 16'h0010; bus2.req_valid = 1'b1;
      n = 0;
      while (n < 20) begin @(negedge clk); if (bus2.req_ready) break; n++; end
      check_eq("to_accept1", (n < 20) ? 32'd1 : 32'd0, 32'd1);
      @(posedge clk); #1 bus2.req_valid = 1'b0;
      n = 0;
      while (n < 50) begin @(negedge clk); if (bus2.rsp_valid) break; n++; end
      check_eq("to_read_latency", n, 3);
      check_eq("to_read_err", bus2.rsp_err, 0);
      check_eq("to_read_rdata", bus2.rsp_rdata, 32'h4A);
      check_eq("to_read_enables", en2_cnt, 1);
      @(posedge clk); #1;
      en_before = en2_cnt;
      bus2.mem_busy = 1'b1;
      bus2.req_we = 1'b1; bus2.req_addr = 16'h0020; bus2.req_wdata = 8'h99; bus2.req_valid = 1'b1;
      n = 0;
      while (n < 20) begin @(negedge clk); if (bus2.req_ready) break; n++; end
      check_eq("to_accept2", (n < 20) ? 32'd1 : 32'd0, 32'd1);
      @(posedge clk); #1 bus2.req_valid = 1'b0;
      n = 0;
      while (n < 50) begin @(negedge clk); if (bus2.rsp_valid) break; n++; end
      check_eq("to_timeout_latency", n, 8);
      check_eq("to_timeout_err", bus2.rsp_err, 1);
      check_eq("to_timeout_rdata_kept", bus2.rsp_rdata, 32'h4A);
      check_eq("to_timeout_no_enable", en2_cnt, en_before);
      @(posedge clk); #1;
      check_eq("to_back_idle", bus2.req_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
